hilo_muldiv_ctrl: RTL and testbench

//  Multi-cycle sequencer for MULTU/DIVU and owner of the HI/LO registers.

---
 rtl/hilo_muldiv_if.sv | 26 ++
 rtl/hilo_muldiv_ctrl.sv | 121 ++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_if.sv
// EX-side handshake between the pipeline and the HI/LO multiply/divide sequencer.
// The master drives the operation request; the slave returns interlock status and HI/LO.
interface hilo_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             hilo_rd;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, hilo_rd,
    input  stall, busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, hilo_rd,
    output stall, busy, done, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// One-bit-per-cycle MULTU/DIVU sequencer that owns HI/LO and interlocks the pipeline.
// Define HILO_DIVU_EN to compile in the restoring divider; otherwise DIVU requests are ignored.
module hilo_muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic          clk,
  input logic          rst,
  hilo_muldiv_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  // Working product/quotient: {P_hi,P_lo} for MULTU, {remainder,quotient} for DIVU.
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opnd;

  logic               accept;
  logic               div_zero;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

`ifdef HILO_DIVU_EN
  logic               op_q;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;

  assign accept   = bus.start && (state == IDLE);
  assign div_zero = bus.op && (bus.src_b == '0);

  // Remainder shifted left with the next dividend bit, then trial-subtract the divisor.
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd};
  assign div_diff  = div_shift[WIDTH-1:0] - opnd;
  assign div_next  = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                            : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
`else
  assign accept   = bus.start && (state == IDLE) && !bus.op;
  assign div_zero = 1'b0;
`endif

  // The 65th (carry) bit of the shift-add accumulator lives only in mul_sum before the shift.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    acc_next = mul_next;
`ifdef HILO_DIVU_EN
    if (op_q) acc_next = div_next;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (div_zero) begin
              hi_q   <= bus.src_a;
              lo_q   <= '1;
              done_q <= 1'b1;
            end else begin
              state <= BUSY;
              cnt   <= '0;
            end
          end
        end
        BUSY: begin
          if (cnt == LAST_CNT) begin
            state  <= IDLE;
            cnt    <= '0;
            hi_q   <= acc_next[2*WIDTH-1:WIDTH];
            lo_q   <= acc_next[WIDTH-1:0];
            done_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // NOTE: working registers are always loaded on accept before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
`ifdef HILO_DIVU_EN
      op_q <= bus.op;
`endif
      opnd <= bus.op ? bus.src_b : bus.src_a;
      acc  <= bus.op ? {{WIDTH{1'b0}}, bus.src_a} : {{WIDTH{1'b0}}, bus.src_b};
    end else if (state == BUSY) begin
      acc <= acc_next;
    end
  end

  assign bus.busy  = (state == BUSY);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.stall = (state == BUSY) && (bus.hilo_rd || bus.start);
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: expected HI/LO are queued at issue, popped on done.
// Cycle-exact busy/done/stall are checked every cycle; DIVU expectations follow HILO_DIVU_EN.
`timescale 1ns/1ps
module tb_hilo_muldiv_ctrl;
  localparam int WIDTH = 32;
`ifdef HILO_DIVU_EN
  localparam bit DIVU_EN = 1'b1;
`else
  localparam bit DIVU_EN = 1'b0;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
  } result_t;

  logic clk = 1'b0;
  logic rst;

  hilo_muldiv_if #(.WIDTH(WIDTH)) bus ();

  hilo_muldiv_ctrl #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  result_t sb[$];
  result_t cur;
  int      vectors     = 0;
  int      miscompares = 0;

  function automatic result_t model(input bit op_i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    result_t            r;
    logic [2*WIDTH-1:0] p;
    if (!op_i) begin
      p    = (2*WIDTH)'(a) * (2*WIDTH)'(b);
      r.hi = p[2*WIDTH-1:WIDTH];
      r.lo = p[WIDTH-1:0];
    end else if (b == '0) begin
      r.hi = a;
      r.lo = '1;
    end else begin
      r.hi = a % b;
      r.lo = a / b;
    end
    return r;
  endfunction

  // Cycles from the start cycle to the done cycle; 0 means the request is ignored.
  function automatic int op_latency(input bit op_i, input logic [WIDTH-1:0] b);
    if (op_i && !DIVU_EN) return 0;
    if (op_i && b == '0)  return 1;
    return WIDTH + 1;
  endfunction

  // Called at a negedge while the DUT is idle (or in its done cycle).
  task automatic drive_start(input bit op_i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.start = 1'b1;
    bus.op    = op_i;
    bus.src_a = a;
    bus.src_b = b;
    if (op_latency(op_i, b) != 0) sb.push_back(model(op_i, a, b));
  endtask

  // Follows one operation cycle by cycle from the cycle after its start.
  task automatic follow_op(input int lat, input int rd_from, input int glitch_at, input bit chain,
                           input bit n_op, input logic [WIDTH-1:0] n_a, input logic [WIDTH-1:0] n_b);
    int      span;
    bit      exp_busy, exp_done, exp_stall;
    span = (lat == 0) ? 40 : lat;
    for (int k = 1; k <= span; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == 1) begin
        bus.src_a = $urandom;
        bus.src_b = $urandom;
      end
      bus.hilo_rd = (rd_from >= 0) && (k - 1 >= rd_from);
      if (k == glitch_at) begin
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.src_a = $urandom;
        bus.src_b = $urandom;
      end
      exp_busy = (lat == WIDTH + 1) && (k <= WIDTH);
      exp_done = (k == lat);
      if (exp_done && chain) drive_start(n_op, n_a, n_b);
      exp_stall = exp_busy && (bus.hilo_rd || bus.start);
      #1;
      vectors++;
      if ({bus.busy, bus.done, bus.stall} !== {exp_busy, exp_done, exp_stall}) begin
        miscompares++;
        $display("FAIL ctrl cycle N+%0d: busy/done/stall got %b%b%b expected %b%b%b",
                 k, bus.busy, bus.done, bus.stall, exp_busy, exp_done, exp_stall);
      end
      if (exp_done) cur = sb.pop_front();
      vectors++;
      if ({bus.hi, bus.lo} !== cur) begin
        miscompares++;
        $display("FAIL hilo cycle N+%0d: got %h_%h expected %h_%h", k, bus.hi, bus.lo, cur.hi, cur.lo);
      end
    end
    if (!chain) begin
      bus.start   = 1'b0;
      bus.hilo_rd = 1'b0;
    end
  endtask

  task automatic run_op(input bit op_i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int rd_from, input int glitch_at);
    @(negedge clk);
    drive_start(op_i, a, b);
    follow_op(op_latency(op_i, b), rd_from, glitch_at, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if ({bus.busy, bus.done, bus.stall, bus.hi, bus.lo} !== {3'b000, {2*WIDTH{1'b0}}}) begin
        miscompares++;
        $display("FAIL reset: busy/done/stall=%b%b%b hi=%h lo=%h expected all zero",
                 bus.busy, bus.done, bus.stall, bus.hi, bus.lo);
      end
      @(negedge clk);
    end
    cur = '0;
  endtask

  task automatic test_multu_max();
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 0);
    vectors++;
    if ({bus.hi, bus.lo} !== 64'hFFFF_FFFE_0000_0001) begin
      miscompares++;
      $display("FAIL multu_max: got %h_%h expected fffffffe_00000001", bus.hi, bus.lo);
    end
  endtask

  task automatic test_divu();
    run_op(1'b1, 32'd100, 32'd7, -1, 0);
    vectors++;
    if ({bus.hi, bus.lo} !== (DIVU_EN ? {32'd2, 32'd14} : {32'hFFFF_FFFE, 32'h0000_0001})) begin
      miscompares++;
      $display("FAIL divu_100_7: got hi=%0d lo=%0d", bus.hi, bus.lo);
    end
  endtask

  task automatic test_div_zero();
    run_op(1'b1, 32'h0000_1234, 32'd0, -1, 0);
  endtask

  task automatic test_stall_hilo_rd();
    run_op(1'b0, 32'd3, 32'd5, 10, 5);
    vectors++;
    if ({bus.hi, bus.lo} !== {32'd0, 32'd15}) begin
      miscompares++;
      $display("FAIL multu_3x5: got hi=%0d lo=%0d expected hi=0 lo=15", bus.hi, bus.lo);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive_start(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    follow_op(op_latency(1'b0, 32'h9ABC_DEF0), -1, 0, 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    follow_op(op_latency(1'b0, 32'h0001_0000), 3, 0, 1'b1, 1'b1, 32'h0000_ABCD, 32'd0);
    follow_op(op_latency(1'b1, 32'd0), -1, 0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0010);
    follow_op(op_latency(1'b1, 32'h0000_0010), -1, 0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.src_a = 32'h0BAD_F00D;
    bus.src_b = 32'h0000_0777;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == 16) rst = 1'b1;
      #1;
      vectors++;
      if ({bus.busy, bus.done} !== 2'b10) begin
        miscompares++;
        $display("FAIL abort_busy cycle N+%0d: busy/done got %b%b expected 10", k, bus.busy, bus.done);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    cur = '0;
    #1;
    vectors++;
    if ({bus.busy, bus.done, bus.stall, bus.hi, bus.lo} !== {3'b000, {2*WIDTH{1'b0}}}) begin
      miscompares++;
      $display("FAIL abort_reset: busy/done/stall=%b%b%b hi=%h lo=%h expected all zero",
               bus.busy, bus.done, bus.stall, bus.hi, bus.lo);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      vectors++;
      if ({bus.busy, bus.done, bus.hi, bus.lo} !== {2'b00, {2*WIDTH{1'b0}}}) begin
        miscompares++;
        $display("FAIL abort_quiet cycle %0d: busy/done=%b%b hi=%h lo=%h expected 00 and zero",
                 k, bus.busy, bus.done, bus.hi, bus.lo);
      end
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a, b;
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom;
      run_op(1'b0, a, b, int'($urandom_range(0, 31)), 0);
    end
    run_op(1'b1, 32'd5, 32'd9, -1, 0);
    run_op(1'b1, 32'hFFFF_FFFF, 32'd1, -1, 0);
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, -1, 0);
    for (int i = 0; i < 2; i++) begin
      a = $urandom;
      b = $urandom_range(1, 32'h0001_0000);
      run_op(1'b1, a, b, -1, 0);
    end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.op      = 1'b0;
    bus.src_a   = '0;
    bus.src_b   = '0;
    bus.hilo_rd = 1'b0;
    rst         = 1'b1;
    cur         = '0;
    test_reset();
    test_multu_max();
    test_divu();
    test_div_zero();
    test_stall_hilo_rd();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
